// File: rtl/mult_div_unit.sv
// Iterative HI/LO arithmetic unit: shift-add multiply (with accumulate/subtract),
// restoring divide and MTHI/MTLO, with a fixed WIDTH+1 cycle latency.
module mult_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

    state_e               state_q;
    logic [3:0]           op_q;
    logic [WIDTH-1:0]     opnd_q;
    logic [WIDTH-1:0]     a_raw_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic                 sign_a_q;
    logic                 sign_b_q;
    logic                 b_zero_q;
    logic [CntW-1:0]      cnt_q;

    logic                 in_signed;
    logic                 in_div;
    logic [WIDTH-1:0]     abs_a;
    logic [WIDTH-1:0]     abs_b;
    logic                 is_div_q;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH:0]       div_diff;
    logic                 div_ge;
    logic [2*WIDTH-1:0]   div_next;
    logic [2*WIDTH-1:0]   prod;
    logic [2*WIDTH-1:0]   hilo;
    logic [2*WIDTH-1:0]   mul_res;
    logic [WIDTH-1:0]     quot_fix;
    logic [WIDTH-1:0]     rem_fix;
    logic [2*WIDTH-1:0]   div_res;

    always_comb begin
        in_signed = ~op[0];
        in_div    = (op[3:1] == 3'b001);
        abs_a     = (in_signed && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
        abs_b     = (in_signed && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
        is_div_q  = (op_q[3:1] == 3'b001);

        // Multiply: acc holds {partial sum, remaining multiplier bits}.
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};
        mul_next  = {mul_sum, acc_q[WIDTH-1:1]};

        // Divide: acc holds {remainder, dividend bits shifting into quotient bits}.
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        div_ge    = ~div_diff[WIDTH];
        div_next  = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                     acc_q[WIDTH-2:0], div_ge};

        prod      = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
        hilo      = {hi, lo};
        if (!op_q[2]) begin
            mul_res = prod;
        end else if (op_q[1]) begin
            mul_res = hilo - prod;
        end else begin
            mul_res = hilo + prod;
        end

        quot_fix  = (sign_a_q ^ sign_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix   = sign_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        div_res   = b_zero_q ? {a_raw_q, {WIDTH{1'b1}}} : {rem_fix, quot_fix};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            op_q     <= '0;
            opnd_q   <= '0;
            a_raw_q  <= '0;
            acc_q    <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            b_zero_q <= 1'b0;
            cnt_q    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start && op[3:1] == 3'b100) begin
                        if (op[0]) lo <= a;
                        else       hi <= a;
                    end else if (start && !op[3]) begin
                        op_q     <= op;
                        sign_a_q <= in_signed & a[WIDTH-1];
                        sign_b_q <= in_signed & b[WIDTH-1];
                        b_zero_q <= (b == '0);
                        a_raw_q  <= a;
                        opnd_q   <= in_div ? abs_b : abs_a;
                        acc_q    <= {{WIDTH{1'b0}}, (in_div ? abs_a : abs_b)};
                        cnt_q    <= '0;
                        busy     <= 1'b1;
                        state_q  <= StCalc;
                    end
                end
                StCalc: begin
                    acc_q <= is_div_q ? div_next : mul_next;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CntW'(WIDTH - 1)) state_q <= StFix;
                end
                StFix: begin
                    {hi, lo} <= is_div_q ? div_res : mul_res;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    state_q  <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

- Multi-cycle, parametrised HI/LO arithmetic unit for the MIPS core.
- Replaces single-cycle combinational multiply/divide with iterative shift-add multiply and restoring divide, so neither the `*` nor the `/` operator is needed.
- Adds multiply-accumulate and multiply-subtract into HI/LO, plus a start/busy/done handshake the pipeline uses to stall on MFHI/MFLO.
- Sits beside the ALU in the execute stage and owns the architectural HI and LO registers.

## Interface

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits; iteration count equals WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when busy=0.
- op  in  4  operation, sampled with start:
  - 0000 MULT, 0001 MULTU, 0010 DIV, 0011 DIVU
  - 0100 MADD, 0101 MADDU, 0110 MSUB, 0111 MSUBU
  - 1000 MTHI, 1001 MTLO
  - all other codes are ignored (no state change).
- a  in  WIDTH  rs operand (multiplicand / dividend / MT source).
- b  in  WIDTH  rt operand (multiplier / divisor).
- busy  out  1  iterative operation in flight.
- done  out  1  one-cycle pulse: HI/LO just updated by an iterative op.
- hi  out  WIDTH  architectural HI register.
- lo  out  WIDTH  architectural LO register.

## Operation

- **FSM states:** IDLE, CALC, FIX.
- **IDLE:**
  - start with MTHI/MTLO: write a into HI/LO at that edge; stay IDLE; busy and done stay 0.
  - start with any iterative op: latch op. Latch |a| and |b| for signed ops, raw a and b for unsigned ops. Record the result signs. Clear the iteration counter. Go to CALC.
- **CALC:** one iteration per cycle for exactly WIDTH cycles, then go to FIX.
  - Multiply: 2·WIDTH-bit shift-add on magnitudes.
  - Divide: restoring; one quotient bit per cycle, MSB first.
- **FIX:** one cycle. Apply sign correction, apply accumulate, write HI/LO, go to IDLE.
- **Multiply result:** {HI,LO} = 2·WIDTH-bit product, two's-complement negated when the signed operand signs differ.
- **MADD/MADDU:** {HI,LO} ← {HI,LO} + product. **MSUB/MSUBU:** {HI,LO} ← {HI,LO} − product.
  - Both wrap modulo 2^(2·WIDTH).
  - The {HI,LO} used is the value at the FIX edge.
- **DIV:** LO = quotient, truncated toward zero; HI = remainder, carrying the dividend's sign.
- **DIVU:** unsigned quotient and remainder.
- **Divide by zero:** same fixed latency; LO = all ones, HI = a (raw value, both DIV and DIVU).
- **Signed overflow:** DIV of the most-negative value by −1 gives LO = most-negative value, HI = 0.
- **start while busy:** ignored entirely. No queueing; the request is not remembered.
- **hi/lo while busy:** hold their previous values until the FIX edge.
- **reset:** clears HI, LO, busy, done, the counter and the latched operands; state → IDLE.
  - Reset mid-operation abandons the operation; no result is written.
  - reset takes priority over a simultaneous start.

## Timing

- **Reset values:** busy=0, done=0, hi=0, lo=0.
- **Iterative op** with start sampled at edge k:
  - busy=1 from after edge k until after edge k+WIDTH+1 (WIDTH+1 cycles).
  - HI/LO written at edge k+WIDTH+1.
  - done=1 for the single cycle following edge k+WIDTH+1; busy=0 in that same cycle.
  - Latency is fixed at WIDTH+1 cycles (33 for WIDTH=32), independent of operand values.
- **Back-to-back:** a new start may be sampled in the done cycle; its own busy begins after that edge.
- **MTHI/MTLO:** visible on hi/lo one cycle after the sampling edge.
- **Registering:** done and busy are registered outputs; no combinational path from start or op to any output.

## Test plan

- **Reset + MT:** reset 2 cycles → hi=lo=0, busy=0. Then MTHI a=0x12345678 → hi=0x12345678 next cycle, done stays 0.
- **MULT:** a=0xFFFFFFFE (−2), b=3 → after 33 cycles hi=0xFFFFFFFF, lo=0xFFFFFFFA, one done pulse. MULTU with the same operands → hi=0x00000002, lo=0xFFFFFFFA.
- **DIV signs:** DIV a=−7, b=2 → lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1). DIVU a=7, b=0 → lo=0xFFFFFFFF, hi=7. DIV a=0x80000000, b=−1 → lo=0x80000000, hi=0.
- **MADD/MSUB:** preload hi=0, lo=0xFFFFFFFF; MADDU a=1, b=1 → hi=1, lo=0. MSUB a=1, b=1 → hi=0, lo=0xFFFFFFFF.
- **Busy handshake:** during MULT, pulse start with MTLO a=5 at cycle 10 → ignored, lo holds old value until the FIX edge. Issue a new DIVU in the done cycle → accepted, busy reasserts.
- **Reset mid-op:** reset at cycle 15 of a MULT → busy=0, hi=lo=0, no done pulse ever emitted for that op.
